// File: rtl/smoke_inc_target.sv
// RPC target for the smoke bench "inc" method: queues calls, returns arg+1 after LATENCY cycles.
// Optional macro SMOKE_INC_TRACE_EN prints each completed call and full-FIFO stalls in simulation.
module smoke_inc_target #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int ID_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ID_W-1:0]          req_id,
  input  logic [31:0]              req_arg,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [31:0]              rsp_ret,
  output logic [31:0]              calls_done,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_mem_id  [DEPTH];
  logic [31:0]       r_mem_arg [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_req_ready;
  logic [ID_W-1:0]   r_op_id;
  logic [31:0]       r_op_arg;
  logic [CW-1:0]     r_cnt;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [31:0]       r_rsp_ret;
  logic [31:0]       r_calls_done;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic [AW:0]       w_count_next;
  logic [AW-1:0]     w_rd_idx;

  assign w_push       = req_valid && r_req_ready;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_rd_idx     = r_rd_ptr[AW-1:0];
  // The pop decision looks only at the current FIFO, so a same-edge push waits a cycle.
  assign w_pop        = !w_empty && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_ret    = r_rsp_ret;
  assign calls_done = r_calls_done;
  assign pending    = w_count;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr[AW-1:0]]  <= req_id;
      r_mem_arg[r_wr_ptr[AW-1:0]] <= req_arg;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_req_ready <= (w_count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_op_id      <= '0;
      r_op_arg     <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_ret    <= '0;
      r_calls_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_op_id  <= r_mem_id[w_rd_idx];
            r_op_arg <= r_mem_arg[w_rd_idx];
            r_cnt    <= CNT_LOAD;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_id    <= r_op_id;
            r_rsp_ret   <= r_op_arg + 32'd1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_calls_done <= r_calls_done + 32'd1;
            r_rsp_valid  <= 1'b0;
            if (!w_empty) begin
              r_op_id  <= r_mem_id[w_rd_idx];
              r_op_arg <= r_mem_arg[w_rd_idx];
              r_cnt    <= CNT_LOAD;
              r_state  <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SMOKE_INC_TRACE_EN
  always @(posedge clock) begin
    if (reset_n) begin
      if (r_rsp_valid && rsp_ready)
        $display("inc: id=%0d arg=%0d ret=%0d n=%0d", r_rsp_id, r_rsp_ret - 32'd1, r_rsp_ret, r_calls_done + 32'd1);
      if (req_valid && !r_req_ready && (w_count == FULL_CNT))
        $display("inc: stall full");
    end
  end
`else
  // Trace printing is compiled out in the default build.
`endif

endmodule

// File: tb/tb_smoke_inc_target.sv
// Directed self-checking bench for smoke_inc_target (LATENCY=2 main instance, LATENCY=1 throughput instance).
module tb_smoke_inc_target;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqId;
  logic [31:0] reqArg;
  logic        rspValid;
  logic        rspReady;
  logic [7:0]  rspId;
  logic [31:0] rspRet;
  logic [31:0] callsDone;
  logic [2:0]  pending;

  logic        tReset_n;
  logic        tReqValid;
  logic        tReqReady;
  logic [7:0]  tReqId;
  logic [31:0] tReqArg;
  logic        tRspValid;
  logic        tRspReady;
  logic [7:0]  tRspId;
  logic [31:0] tRspRet;
  logic [31:0] tCallsDone;
  logic [2:0]  tPending;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  smoke_inc_target #(.DEPTH(4), .LATENCY(2), .ID_W(8)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(reqValid), .req_ready(reqReady), .req_id(reqId), .req_arg(reqArg),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId), .rsp_ret(rspRet),
    .calls_done(callsDone), .pending(pending)
  );

  smoke_inc_target #(.DEPTH(4), .LATENCY(1), .ID_W(8)) u_dut_lat1 (
    .clock(clock), .reset_n(tReset_n),
    .req_valid(tReqValid), .req_ready(tReqReady), .req_id(tReqId), .req_arg(tReqArg),
    .rsp_valid(tRspValid), .rsp_ready(tRspReady), .rsp_id(tRspId), .rsp_ret(tRspRet),
    .calls_done(tCallsDone), .pending(tPending)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] id, input logic [31:0] arg, output bit ok);
    reqValid = 1'b1;
    reqId    = id;
    reqArg   = arg;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (reqReady) ok = 1'b1;
      tick();
    end
    reqValid = 1'b0;
  endtask

  task automatic waitResp(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (rspValid) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    total++; if (reqReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready got %b want 0", reqReady); end
    total++; if (rspValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rspValid); end
    total++; if (rspId !== 8'd0) begin bad++; $display("[TB] FAIL reset_rsp_id got %0d want 0", rspId); end
    total++; if (rspRet !== 32'd0) begin bad++; $display("[TB] FAIL reset_rsp_ret got %h want 0", rspRet); end
    total++; if (callsDone !== 32'd0) begin bad++; $display("[TB] FAIL reset_calls_done got %0d want 0", callsDone); end
    total++; if (pending !== 3'd0) begin bad++; $display("[TB] FAIL reset_pending got %0d want 0", pending); end
    reset_n = 1'b1;
    tick();
    total++; if (reqReady !== 1'b1) begin bad++; $display("[TB] FAIL release_req_ready got %b want 1", reqReady); end
  endtask

  task automatic test_single_call();
    rspReady = 1'b1;
    reqValid = 1'b1; reqId = 8'd1; reqArg = 32'd41;
    tick();
    reqValid = 1'b0;
    // Edge E has just passed; rsp_valid must first rise after E+3.
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (rspValid !== (k == 3)) begin bad++; $display("[TB] FAIL single_latency k=%0d got %b want %b", k, rspValid, (k == 3)); end
    end
    total++; if (rspId !== 8'd1) begin bad++; $display("[TB] FAIL single_id got %0d want 1", rspId); end
    total++; if (rspRet !== 32'd42) begin bad++; $display("[TB] FAIL single_ret got %0d want 42", rspRet); end
    tick();
    total++; if (callsDone !== 32'd1) begin bad++; $display("[TB] FAIL single_calls_done got %0d want 1", callsDone); end
    total++; if (rspValid !== 1'b0) begin bad++; $display("[TB] FAIL single_rsp_drop got %b want 0", rspValid); end
  endtask

  task automatic test_wrap();
    bit ok, seen;
    rspReady = 1'b1;
    push(8'd2, 32'hFFFF_FFFF, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL wrap_push got 0 want 1"); end
    waitResp(seen);
    total++; if (!seen) begin bad++; $display("[TB] FAIL wrap_timeout got 0 want 1"); end
    total++; if (rspRet !== 32'h0000_0000) begin bad++; $display("[TB] FAIL wrap_ret got %h want 00000000", rspRet); end
    total++; if (rspId !== 8'd2) begin bad++; $display("[TB] FAIL wrap_id got %0d want 2", rspId); end
    tick();
    total++; if (callsDone !== 32'd2) begin bad++; $display("[TB] FAIL wrap_calls_done got %0d want 2", callsDone); end
  endtask

  task automatic test_stable_hold();
    for (int c = 0; c < 10; c++) begin
      total++;
      if (rspValid !== 1'b1 || rspId !== 8'd0 || rspRet !== 32'd101) begin
        bad++;
        $display("[TB] FAIL hold_c%0d got v=%b id=%0d ret=%0d want v=1 id=0 ret=101", c, rspValid, rspId, rspRet);
      end
      tick();
    end
  endtask

  task automatic test_fill_backpressure();
    bit ok, seen;
    applyReset();
    rspReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(8'(i), 32'(100 + i), ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL fill_push%0d got 0 want 1", i); end
    end
    total++; if (reqReady !== 1'b0) begin bad++; $display("[TB] FAIL fill_req_ready got %b want 0", reqReady); end
    total++; if (pending !== 3'd4) begin bad++; $display("[TB] FAIL fill_pending got %0d want 4", pending); end
    test_stable_hold();
    rspReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitResp(seen);
      total++;
      if (!seen || rspId !== 8'(i) || rspRet !== 32'(101 + i)) begin
        bad++;
        $display("[TB] FAIL order_%0d got seen=%b id=%0d ret=%0d want id=%0d ret=%0d", i, seen, rspId, rspRet, i, 101 + i);
      end
      tick();
    end
    total++; if (callsDone !== 32'd5) begin bad++; $display("[TB] FAIL fill_calls_done got %0d want 5", callsDone); end
  endtask

  task automatic test_mid_reset();
    bit ok, seen;
    rspReady = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(20 + i), 32'(i), ok);
    total++; if (pending !== 3'd2) begin bad++; $display("[TB] FAIL midrst_pre_pending got %0d want 2", pending); end
    total++; if (rspValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pre_busy got %b want 0", rspValid); end
    reqValid = 1'b1; reqId = 8'd99; reqArg = 32'd5;
    reset_n  = 1'b0;
    tick();
    reqValid = 1'b0;
    total++; if (rspValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rsp_valid got %b want 0", rspValid); end
    total++; if (pending !== 3'd0) begin bad++; $display("[TB] FAIL midrst_pending got %0d want 0", pending); end
    total++; if (callsDone !== 32'd0) begin bad++; $display("[TB] FAIL midrst_calls_done got %0d want 0", callsDone); end
    reset_n = 1'b1;
    tick();
    rspReady = 1'b1;
    push(8'd9, 32'd7, ok);
    waitResp(seen);
    total++;
    if (!seen || rspId !== 8'd9 || rspRet !== 32'd8) begin
      bad++;
      $display("[TB] FAIL midrst_next got seen=%b id=%0d ret=%0d want id=9 ret=8", seen, rspId, rspRet);
    end
    tick();
    total++; if (callsDone !== 32'd1) begin bad++; $display("[TB] FAIL midrst_next_done got %0d want 1", callsDone); end
  endtask

  task automatic test_throughput();
    int got = 0;
    int lastCyc = -1;
    tRspReady = 1'b1;
    tReset_n  = 1'b0;
    tick();
    tReset_n = 1'b1;
    tick();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          tReqValid = 1'b1; tReqId = 8'(50 + i); tReqArg = 32'(1000 + i);
          for (int w = 0; w < 50; w++) begin
            if (tReqReady) break;
            tick();
          end
          tick();
        end
        tReqValid = 1'b0;
      end
      begin
        for (int c = 0; c < 200 && got < 8; c++) begin
          tick();
          if (tRspValid) begin
            total++;
            if (tRspId !== 8'(50 + got) || tRspRet !== 32'(1001 + got)) begin
              bad++;
              $display("[TB] FAIL tput_data%0d got id=%0d ret=%0d want id=%0d ret=%0d", got, tRspId, tRspRet, 50 + got, 1001 + got);
            end
            if (got > 0) begin
              total++;
              if (c - lastCyc != 2) begin bad++; $display("[TB] FAIL tput_gap%0d got %0d want 2", got, c - lastCyc); end
            end
            lastCyc = c;
            got++;
          end
        end
      end
    join
    total++; if (got != 8) begin bad++; $display("[TB] FAIL tput_count got %0d want 8", got); end
    tick();
    total++; if (tCallsDone !== 32'd8) begin bad++; $display("[TB] FAIL tput_calls_done got %0d want 8", tCallsDone); end
  endtask

  initial begin
    reset_n = 1'b0; reqValid = 1'b0; reqId = '0; reqArg = '0; rspReady = 1'b0;
    tReset_n = 1'b0; tReqValid = 1'b0; tReqId = '0; tReqArg = '0; tRspReady = 1'b0;
    test_reset();
    test_single_call();
    test_wrap();
    test_fill_backpressure();
    test_mid_reset();
    test_throughput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
